// File: rtl/ex_branch_buffer.sv
// Execute-stage back end: a 2-entry EX/MEM FIFO fed by the ALU and ID/EX controls,
// plus predict-not-taken branch/jump resolution with a registered 1-cycle redirect to fetch.
module ex_branch_buffer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] imm,
  input  logic              is_branch,
  input  logic [2:0]        br_funct3,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic [4:0]        rd,
  input  logic              reg_wen,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [WORD_W-1:0] store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_reg_wen,
  output logic              out_mem_ren,
  output logic              out_mem_wen,
  output logic [WORD_W-1:0] out_store_data,
  output logic              out_ovf,
  output logic              redirect_valid,
  output logic [WORD_W-1:0] redirect_pc
);

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] store_data;
    logic [4:0]        rd;
    logic              reg_wen;
    logic              mem_ren;
    logic              mem_wen;
    logic              ovf;
  } entry_t;

  logic [1:0]             count_reg;
  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic                   accept;
  logic                   pop;
  logic                   taken;
  logic                   redirect_req;
  logic [WORD_W-1:0]      target;
  logic [WORD_W-1:0]      link;
  entry_t                 new_entry;
  entry_t                 head;
  entry_t [DEPTH-1:0]     entries;

  assign in_ready  = (count_reg != 2'd2) && !RST;
  assign out_valid = (count_reg != 2'd0) && !RST;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Compare branches reuse the ALU: SUB for BEQ/BNE, SLT/SLTU (result bit 0) for the rest.
  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (br_funct3)
        3'b000:  taken = alu_zero;
        3'b001:  taken = !alu_zero;
        3'b100:  taken = alu_out[0];
        3'b101:  taken = !alu_out[0];
        3'b110:  taken = alu_out[0];
        3'b111:  taken = !alu_out[0];
        default: taken = 1'b0;
      endcase
    end
  end

  assign redirect_req = taken || is_jal || is_jalr;
  assign link         = pc + WORD_W'(4);
  assign target       = is_jalr ? (alu_out & ~WORD_W'(1)) : (pc + imm);

  // Branches never write back or touch memory, whatever the decoder sent along.
  always_comb begin
    new_entry            = '0;
    new_entry.result     = (is_jal || is_jalr) ? link : alu_out;
    new_entry.store_data = store_data;
    new_entry.rd         = rd;
    new_entry.reg_wen    = reg_wen && !is_branch;
    new_entry.mem_ren    = mem_ren && !is_branch;
    new_entry.mem_wen    = mem_wen && !is_branch;
    new_entry.ovf        = alu_ovf;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t entry_reg;
      always_ff @(posedge CLK) begin
        if (RST) begin
          entry_reg <= '0;
        end else if (accept && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= new_entry;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg      <= 2'd0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      count_reg      <= 2'd0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)    rd_ptr_reg <= ~rd_ptr_reg;
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      redirect_valid <= accept && redirect_req;
      if (accept && redirect_req) redirect_pc <= target;
    end
  end

  assign head           = entries[rd_ptr_reg];
  assign out_result     = head.result;
  assign out_rd         = head.rd;
  assign out_reg_wen    = head.reg_wen;
  assign out_mem_ren    = head.mem_ren;
  assign out_mem_wen    = head.mem_wen;
  assign out_store_data = head.store_data;
  assign out_ovf        = head.ovf;

endmodule

// File: tb/tb_ex_branch_buffer.sv
// Bench for ex_branch_buffer: directed scenarios plus a randomized run checked
// against a queue-based model of the buffer and the branch/jump rules.
module tb_ex_branch_buffer;

  logic        CLK = 1'b0;
  logic        RST, flush, in_valid, in_ready;
  logic [31:0] alu_out, pc, imm, store_data;
  logic        alu_zero, alu_ovf, is_branch, is_jal, is_jalr;
  logic [2:0]  br_funct3;
  logic [4:0]  rd;
  logic        reg_wen, mem_ren, mem_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic        out_reg_wen, out_mem_ren, out_mem_wen, out_ovf, redirect_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        reg_wen, mem_ren, mem_wen, ovf;
  } exp_t;

  exp_t        mq[$];
  logic        m_rv  = 1'b0;
  logic [31:0] m_rpc = 32'd0;

  always #5 CLK = ~CLK;

  ex_branch_buffer #(.WORD_W(32), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .pc(pc), .imm(imm),
    .is_branch(is_branch), .br_funct3(br_funct3), .is_jal(is_jal), .is_jalr(is_jalr),
    .rd(rd), .reg_wen(reg_wen), .mem_ren(mem_ren), .mem_wen(mem_wen), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_wen(out_reg_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_store_data(out_store_data), .out_ovf(out_ovf),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // kind: 0 plain ALU op, 1 conditional branch, 2 JAL, 3 JALR
  task automatic load(input int kind, input logic [2:0] f3, input logic [31:0] a,
                      input logic z, input logic [31:0] p, input logic [31:0] i);
    alu_out = a; alu_zero = z; alu_ovf = 1'b0; pc = p; imm = i;
    is_branch = (kind == 1); br_funct3 = f3; is_jal = (kind == 2); is_jalr = (kind == 3);
    rd = 5'(kind + 1); reg_wen = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0;
    store_data = a ^ 32'hA5A5_A5A5;
  endtask

  // Advance one clock; the model applies the buffer rules to the inputs present at the edge.
  task automatic tick();
    logic  acc, pp, taken, redir;
    logic  [31:0] tgt;
    exp_t  e;
    acc   = !RST && !flush && in_valid && (mq.size() < 2);
    pp    = !RST && !flush && out_ready && (mq.size() > 0);
    taken = 1'b0;
    if (is_branch) begin
      if (br_funct3 == 3'b000) taken = alu_zero;
      else if (br_funct3 == 3'b001) taken = !alu_zero;
      else if (br_funct3 == 3'b100 || br_funct3 == 3'b110) taken = alu_out[0];
      else if (br_funct3 == 3'b101 || br_funct3 == 3'b111) taken = !alu_out[0];
    end
    redir     = taken || is_jal || is_jalr;
    tgt       = is_jalr ? (alu_out & 32'hFFFF_FFFE) : (pc + imm);
    e.result  = (is_jal || is_jalr) ? (pc + 32'd4) : alu_out;
    e.sd      = store_data;
    e.rd      = rd;
    e.reg_wen = is_branch ? 1'b0 : reg_wen;
    e.mem_ren = is_branch ? 1'b0 : mem_ren;
    e.mem_wen = is_branch ? 1'b0 : mem_wen;
    e.ovf     = alu_ovf;
    @(posedge CLK);
    if (RST || flush) begin
      mq.delete();
      m_rv = 1'b0;
      if (RST) m_rpc = 32'd0;
    end else begin
      if (pp) begin
        $display("pop    result=%h rd=%0d", mq[0].result, mq[0].rd);
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back(e);
        $display("accept result=%h redirect=%0d target=%h", e.result, redir, tgt);
      end
      m_rv = acc && redir;
      if (acc && redir) m_rpc = tgt;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    load(0, 3'b000, 32'h55, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b redirect_valid=%b required 0 0 0",
                 in_ready, out_valid, redirect_valid);
      end
    end
    RST = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load(0, 3'b000, vals[k], 1'b0, 32'h40 + 32'(4 * k), 32'h0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h11) begin
        errors++;
        $display("FAIL fill_full: in_ready=%b out_valid=%b result=%h required 0 1 00000011",
                 in_ready, out_valid, out_result);
      end
      if (k == 0) tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== vals[k]) begin
        errors++;
        $display("FAIL drain_order: step=%0d out_valid=%b result=%h required 1 %h",
                 k, out_valid, out_result, vals[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_branch();
    out_ready = 1'b1; in_valid = 1'b1;
    load(1, 3'b000, 32'h0, 1'b1, 32'h100, 32'h40);
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140 || out_reg_wen !== 1'b0) begin
      errors++;
      $display("FAIL beq_taken: redirect=%b pc=%h reg_wen=%b required 1 00000140 0",
               redirect_valid, redirect_pc, out_reg_wen);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_pulse: redirect=%b required 0", redirect_valid);
    end
    in_valid = 1'b1;
    load(1, 3'b110, 32'h0, 1'b0, 32'h180, 32'h20);
    mem_wen = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || out_reg_wen !== 1'b0 || out_mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL bltu_not_taken: redirect=%b valid=%b reg_wen=%b mem_wen=%b required 0 1 0 0",
               redirect_valid, out_valid, out_reg_wen, out_mem_wen);
    end
    tick();
  endtask

  task automatic test_jumps();
    out_ready = 1'b1; in_valid = 1'b1;
    load(2, 3'b000, 32'h0, 1'b0, 32'h200, 32'hFFFF_FFF8);
    tick();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1F8 || out_result !== 32'h204 || out_reg_wen !== 1'b1) begin
      errors++;
      $display("FAIL jal: redirect=%b pc=%h result=%h reg_wen=%b required 1 000001f8 00000204 1",
               redirect_valid, redirect_pc, out_result, out_reg_wen);
    end
    load(3, 3'b000, 32'h305, 1'b0, 32'h300, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || out_result !== 32'h304) begin
      errors++;
      $display("FAIL jalr: redirect=%b pc=%h result=%h required 1 00000304 00000304",
               redirect_valid, redirect_pc, out_result);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load(0, 3'b000, 32'(k + 1), 1'b0, 32'h0, 32'h0);
      tick();
    end
    load(1, 3'b000, 32'h0, 1'b1, 32'h400, 32'h10);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: out_valid=%b redirect=%b in_ready=%b required 0 0 1",
               out_valid, redirect_valid, in_ready);
    end
    out_ready = 1'b0;
    load(0, 3'b000, 32'h77, 1'b0, 32'h0, 32'h0);
    tick();
    load(2, 3'b000, 32'h0, 1'b0, 32'h500, 32'h8);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_jal: out_valid=%b redirect=%b required 0 0", out_valid, redirect_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      load(0, 3'b000, 32'hA0 + 32'(k), 1'b0, 32'h0, 32'h0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready: op=%0d in_ready=%b required 1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL wrap_order: op=%0d valid=%b result=%h required 1 %h",
                 k, out_valid, out_result, 32'hA0 + 32'(k));
      end
    end
    load(2, 3'b000, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h8);
    tick();
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL jal_wrap: redirect=%b pc=%h result=%h required 1 00000004 00000000",
               redirect_valid, redirect_pc, out_result);
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load(int'($urandom_range(0, 3)), 3'($urandom), $urandom, 1'($urandom),
           ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom, $urandom);
      rd = 5'($urandom); reg_wen = 1'($urandom); alu_ovf = 1'($urandom);
      mem_ren = is_branch ? 1'b0 : 1'($urandom);
      mem_wen = is_branch ? 1'b0 : 1'($urandom);
      store_data = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      RST       = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (in_ready !== (!RST && mq.size() < 2) || out_valid !== (!RST && mq.size() > 0)) begin
        errors++;
        $display("FAIL rand_flags: cycle=%0d in_ready=%b out_valid=%b required %b %b",
                 c, in_ready, out_valid, !RST && mq.size() < 2, !RST && mq.size() > 0);
      end
      if (!RST && mq.size() > 0) begin
        checks++;
        if (out_result !== mq[0].result || out_rd !== mq[0].rd || out_reg_wen !== mq[0].reg_wen ||
            out_mem_ren !== mq[0].mem_ren || out_mem_wen !== mq[0].mem_wen ||
            out_store_data !== mq[0].sd || out_ovf !== mq[0].ovf) begin
          errors++;
          $display("FAIL rand_head: cycle=%0d got %h/%0d/%b%b%b/%h/%b required %h/%0d/%b%b%b/%h/%b",
                   c, out_result, out_rd, out_reg_wen, out_mem_ren, out_mem_wen, out_store_data, out_ovf,
                   mq[0].result, mq[0].rd, mq[0].reg_wen, mq[0].mem_ren, mq[0].mem_wen, mq[0].sd, mq[0].ovf);
        end
      end
      tick();
      checks++;
      if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
        errors++;
        $display("FAIL rand_redirect: cycle=%0d redirect=%b pc=%h required %b %h",
                 c, redirect_valid, redirect_pc, m_rv, m_rpc);
      end
    end
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_branch();
    test_jumps();
    test_flush();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
